// File: rtl/tcp_conn_arbiter_if.sv
// Handshake bundle between the connection arbiter, its NUM_REQ requesters and the TCP stack.
// The slave modport is the arbiter's view; the master modport is the view of the requesters
// and the stack together.
interface tcp_conn_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  // Open requests from the requesters
  logic [NUM_REQ-1:0]    s_req_valid;
  logic [NUM_REQ-1:0]    s_req_ready;
  logic [NUM_REQ*48-1:0] s_req_data;
  // Open-connection command to the stack
  logic                  m_open_valid;
  logic                  m_open_ready;
  logic [47:0]           m_open_data;
  // Open status from the stack
  logic                  s_status_valid;
  logic                  s_status_ready;
  logic [16:0]           s_status_data;
  // Open response back to the requesters
  logic [NUM_REQ-1:0]    m_rsp_valid;
  logic [NUM_REQ-1:0]    m_rsp_ready;
  logic [17:0]           m_rsp_data;
  // Close requests from the requesters
  logic [NUM_REQ-1:0]    s_close_valid;
  logic [NUM_REQ-1:0]    s_close_ready;
  logic [NUM_REQ*16-1:0] s_close_data;
  // Close-connection command to the stack
  logic                  m_close_valid;
  logic                  m_close_ready;
  logic [15:0]           m_close_data;

  modport slave (
    input  s_req_valid, s_req_data, m_open_ready, s_status_valid, s_status_data,
    input  m_rsp_ready, s_close_valid, s_close_data, m_close_ready,
    output s_req_ready, m_open_valid, m_open_data, s_status_ready, m_rsp_valid, m_rsp_data,
    output s_close_ready, m_close_valid, m_close_data
  );

  modport master (
    output s_req_valid, s_req_data, m_open_ready, s_status_valid, s_status_data,
    output m_rsp_ready, s_close_valid, s_close_data, m_close_ready,
    input  s_req_ready, m_open_valid, m_open_data, s_status_ready, m_rsp_valid, m_rsp_data,
    input  s_close_ready, m_close_valid, m_close_data
  );
endinterface

// File: rtl/tcp_conn_arbiter.sv
// Shares the TCP stack's open-connection and close-connection ports among NUM_REQ requesters.
// Open path: round-robin, one open outstanding, status routed back to the granted requester
// with a timeout. Close path: independent round-robin through a 1-entry output register.
// Optional feature macro: TCP_ARB_STATS_EN adds saturating 32-bit event counters.
module tcp_conn_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [31:0] TIME_OUT_CYCLE = 32'hDF84_7580
) (
  input  logic               clk,
  input  logic               rst,
  tcp_conn_arbiter_if.slave  bus,
  output logic               busy_o
`ifdef TCP_ARB_STATS_EN
  ,
  output logic [31:0]        stat_open_ok_o,
  output logic [31:0]        stat_open_fail_o,
  output logic [31:0]        stat_timeout_o,
  output logic [31:0]        stat_stale_o
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     open_ptr_q;
  logic [IdxW-1:0]     close_ptr_q;
  logic [IdxW-1:0]     grant_q;
  logic [47:0]         open_data_q;
  logic                open_valid_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [17:0]         rsp_data_q;
  logic [31:0]         timer_q;
  logic                close_valid_q;
  logic [15:0]         close_data_q;

  logic                open_found;
  logic [IdxW-1:0]     open_grant;
  logic                close_found;
  logic [IdxW-1:0]     close_grant;

  // Returns {found, index} of the first set bit searching upward from ptr, wrapping.
  function automatic logic [IdxW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IdxW-1:0]    ptr);
    logic [IdxW:0] res;
    int            idx;
    res = '0;
    // Descending offset so the nearest candidate to ptr is written last and wins.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (valid[idx[IdxW-1:0]]) res = {1'b1, idx[IdxW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] g);
    return (int'(g) == int'(NUM_REQ) - 1) ? '0 : g + 1'b1;
  endfunction

  assign {open_found, open_grant}   = rr_pick(bus.s_req_valid, open_ptr_q);
  assign {close_found, close_grant} = rr_pick(bus.s_close_valid, close_ptr_q);

  // Accept pulses are combinational so the accept lands in the same cycle the grant is chosen.
  always_comb begin
    bus.s_req_ready = '0;
    if (state_q == StIdle && open_found) bus.s_req_ready[open_grant] = 1'b1;
  end

  // Close accept only while the output register is empty; never in its draining cycle.
  always_comb begin
    bus.s_close_ready = '0;
    if (!close_valid_q && close_found) bus.s_close_ready[close_grant] = 1'b1;
  end

  assign bus.m_open_valid   = open_valid_q;
  assign bus.m_open_data    = open_data_q;
  assign bus.s_status_ready = 1'b1;
  assign bus.m_rsp_valid    = rsp_valid_q;
  assign bus.m_rsp_data     = rsp_data_q;
  assign bus.m_close_valid  = close_valid_q;
  assign bus.m_close_data   = close_data_q;
  assign busy_o             = (state_q != StIdle);

  // Open FSM: grant, issue to the stack, wait for status or timeout, respond to the grantee.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      open_ptr_q   <= '0;
      grant_q      <= '0;
      open_data_q  <= '0;
      open_valid_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      timer_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (open_found) begin
            grant_q      <= open_grant;
            open_data_q  <= bus.s_req_data[48*open_grant +: 48];
            open_ptr_q   <= next_idx(open_grant);
            open_valid_q <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (bus.m_open_ready) begin
            open_valid_q <= 1'b0;
            timer_q      <= '0;
            state_q      <= StWait;
          end
        end
        StWait: begin
          // Status has priority over a timeout landing in the same cycle.
          if (bus.s_status_valid) begin
            rsp_data_q  <= {1'b0, bus.s_status_data};
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q     <= StResp;
          end else if (timer_q == TIME_OUT_CYCLE) begin
            rsp_data_q  <= {1'b1, 1'b0, 16'h0000};
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q     <= StResp;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        StResp: begin
          if (bus.m_rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Close path: refill the 1-entry register only when it is empty at the start of the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      close_valid_q <= 1'b0;
      close_data_q  <= '0;
      close_ptr_q   <= '0;
    end else if (close_valid_q) begin
      if (bus.m_close_ready) close_valid_q <= 1'b0;
    end else if (close_found) begin
      close_valid_q <= 1'b1;
      close_data_q  <= bus.s_close_data[16*close_grant +: 16];
      close_ptr_q   <= next_idx(close_grant);
    end
  end

`ifdef TCP_ARB_STATS_EN
  logic [31:0] stat_ok_q, stat_fail_q, stat_to_q, stat_stale_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters; a status seen outside WAIT is stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ok_q    <= '0;
      stat_fail_q  <= '0;
      stat_to_q    <= '0;
      stat_stale_q <= '0;
    end else begin
      if (state_q == StWait && bus.s_status_valid) begin
        if (bus.s_status_data[16]) stat_ok_q <= sat_inc(stat_ok_q);
        else                       stat_fail_q <= sat_inc(stat_fail_q);
      end
      if (state_q == StWait && !bus.s_status_valid && timer_q == TIME_OUT_CYCLE) begin
        stat_to_q <= sat_inc(stat_to_q);
      end
      if (state_q != StWait && bus.s_status_valid) stat_stale_q <= sat_inc(stat_stale_q);
    end
  end

  assign stat_open_ok_o   = stat_ok_q;
  assign stat_open_fail_o = stat_fail_q;
  assign stat_timeout_o   = stat_to_q;
  assign stat_stale_o     = stat_stale_q;
`endif

endmodule
